// File: rtl/avalon_pkg.sv
// Shared types and constants for the Avalon-MM RAM slave model.
package avalon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } ram_state_t;

    localparam int         BYTE_LANES = 4;
    localparam logic [7:0] LFSR_SEED  = 8'hA5;
    // Taps 8,6,5,4 of a Fibonacci LFSR, numbered from 1 at the LSB
    localparam logic [7:0] LFSR_TAPS  = 8'b1011_1000;

endpackage

// File: rtl/avalon_wait_lfsr.sv
// Free-running 8-bit Fibonacci LFSR that adds pseudo-random stalls.
// Instantiated only when AVALON_RANDOM_WAIT_EN is defined.
import avalon_pkg::*;

module avalon_wait_lfsr (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] lfsr
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/avalon_ram_slave.sv
// Word-addressed 32-bit RAM acting as an Avalon-MM slave with programmable stalls.
// Define AVALON_RANDOM_WAIT_EN to add 0..3 LFSR-driven extra wait cycles per access.
import avalon_pkg::*;

module avalon_ram_slave #(
    parameter string RAM_INIT_FILE = "",
    parameter int    ADDR_BITS     = 14,
    parameter int    WAIT_CYCLES   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        protocol_error
);

    localparam int WORDS = 1 << ADDR_BITS;

    if (WAIT_CYCLES < 1) begin : g_bad_wait
        $fatal(1, "avalon_ram_slave: WAIT_CYCLES must be at least 1");
    end

    logic [31:0]          mem [WORDS];
    ram_state_t           state, state_next;
    logic [31:0]          lat_addr;
    logic                 lat_read;
    logic [15:0]          count;
    logic [15:0]          start_count;
    logic [ADDR_BITS-1:0] idx;
    logic                 both, op_match, addr_match;
    logic                 start, count_dec, load_read, set_err, commit;

    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = 32'd0;
    end

`ifdef AVALON_RANDOM_WAIT_EN
    logic [7:0] lfsr;

    avalon_wait_lfsr u_wait_lfsr (
        .clk  (clk),
        .rst  (rst),
        .lfsr (lfsr)
    );

    assign start_count = 16'(WAIT_CYCLES - 1) + 16'(lfsr[1:0]);
`else
    assign start_count = 16'(WAIT_CYCLES - 1);
`endif

    // Upper address bits alias onto the same words
    assign idx        = lat_addr[ADDR_BITS+1:2];
    assign both       = read && write;
    assign op_match   = (read == lat_read) && (write == !lat_read);
    assign addr_match = (address == lat_addr);

    assign waitrequest = !rst || both || ((read || write) && (state != DONE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Aborts take priority over progress so a violating master never commits
    always_comb begin
        state_next = state;
        start      = 1'b0;
        count_dec  = 1'b0;
        load_read  = 1'b0;
        set_err    = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (both) begin
                    set_err = 1'b1;
                end else if (read || write) begin
                    start      = 1'b1;
                    set_err    = (address[1:0] != 2'b00);
                    state_next = BUSY;
                end
            end
            BUSY, DONE: begin
                if (both) begin
                    set_err    = 1'b1;
                    state_next = IDLE;
                end else if (!op_match) begin
                    state_next = IDLE;
                end else if (!addr_match) begin
                    set_err    = 1'b1;
                    state_next = IDLE;
                end else if (state == DONE) begin
                    commit     = !lat_read;
                    state_next = IDLE;
                end else if (count != 16'd0) begin
                    count_dec  = 1'b1;
                end else begin
                    load_read  = lat_read;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_addr       <= 32'd0;
            lat_read       <= 1'b0;
            count          <= 16'd0;
            readdata       <= 32'd0;
            protocol_error <= 1'b0;
        end else begin
            if (start) begin
                lat_addr <= address;
                lat_read <= read;
                count    <= start_count;
            end
            if (count_dec) count <= count - 16'd1;
            if (load_read) readdata <= mem[idx];
            if (set_err) protocol_error <= 1'b1;
        end
    end

    // Memory is deliberately outside the reset domain so contents survive reset
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < BYTE_LANES; i++) begin
                if (byteenable[i]) mem[idx][8*i +: 8] <= writedata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_avalon_ram_slave.sv
// Scoreboard bench for avalon_ram_slave: one instance with 1 wait cycle, one with 3.
module tb_avalon_ram_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address, writedata;
    logic        read, write, sel;
    logic [3:0]  byteenable;

    logic        read1, write1, read3, write3;
    logic        wr1, wr3, pe1, pe3;
    logic [31:0] rd1, rd3;
    logic        wr_sel;
    logic [31:0] rd_sel;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    assign read1  = read  && !sel;
    assign write1 = write && !sel;
    assign read3  = read  && sel;
    assign write3 = write && sel;
    assign wr_sel = sel ? wr3 : wr1;
    assign rd_sel = sel ? rd3 : rd1;

    avalon_ram_slave #(.RAM_INIT_FILE(""), .ADDR_BITS(14), .WAIT_CYCLES(1)) dut_w1 (
        .clk            (clk),
        .rst            (rst),
        .address        (address),
        .read           (read1),
        .write          (write1),
        .writedata      (writedata),
        .byteenable     (byteenable),
        .waitrequest    (wr1),
        .readdata       (rd1),
        .protocol_error (pe1)
    );

    avalon_ram_slave #(.RAM_INIT_FILE(""), .ADDR_BITS(14), .WAIT_CYCLES(3)) dut_w3 (
        .clk            (clk),
        .rst            (rst),
        .address        (address),
        .read           (read3),
        .write          (write3),
        .writedata      (writedata),
        .byteenable     (byteenable),
        .waitrequest    (wr3),
        .readdata       (rd3),
        .protocol_error (pe3)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Completed reads are compared against the queue independently of the stimulus
    always @(negedge clk) begin
        if (rst && read && !write && !wr_sel) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected read: got %h, expected no completion", rd_sel);
            end else begin
                check_output("read data", rd_sel, exp_q.pop_front());
            end
        end
    end

    task automatic apply_stimulus(input logic s, input logic is_read, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] be,
                                  input int exp_lat, input logic [31:0] exp_rdata,
                                  input string name);
        int cycles;
        cycles     = 0;
        sel        = s;
        address    = addr;
        writedata  = wdata;
        byteenable = be;
        if (is_read) exp_q.push_back(exp_rdata);
        read  = is_read;
        write = !is_read;
        do begin
            @(negedge clk);
            if (wr_sel) cycles++;
        end while (wr_sel && cycles < 50);
        if (wr_sel) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s timeout: waitrequest still 1 after %0d cycles, expected 0", name, cycles);
        end
`ifndef AVALON_RANDOM_WAIT_EN
        else begin
            check_output({name, " latency"}, 32'(cycles), 32'(exp_lat));
        end
`endif
        @(posedge clk);
        #1;
        read  = 1'b0;
        write = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        sel        = 1'b0;
        address    = 32'd0;
        writedata  = 32'd0;
        byteenable = 4'd0;

        @(negedge clk);
        check_output("reset waitrequest w1", 32'(wr1), 32'd1);
        check_output("reset waitrequest w3", 32'(wr3), 32'd1);
        check_output("reset readdata", rd1, 32'd0);
        check_output("reset protocol_error", 32'(pe1), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_output("idle waitrequest w1", 32'(wr1), 32'd0);
        check_output("idle waitrequest w3", 32'(wr3), 32'd0);
        @(posedge clk);
        #1;

        // Reset-vector word, then byte lanes, empty lane mask and address aliasing
        apply_stimulus(0, 0, 32'hBFC00000, 32'h24020005, 4'hF, 2, 32'h0, "write vector");
        apply_stimulus(0, 1, 32'hBFC00000, 32'h0, 4'h0, 2, 32'h24020005, "read vector");
        apply_stimulus(0, 0, 32'h00000010, 32'hAABBCCDD, 4'b0101, 2, 32'h0, "lane write");
        apply_stimulus(0, 1, 32'h00000010, 32'h0, 4'hF, 2, 32'h00BB00DD, "lane read");
        apply_stimulus(0, 0, 32'h00000010, 32'hFFFFFFFF, 4'b0000, 2, 32'h0, "empty write");
        apply_stimulus(0, 1, 32'h00010010, 32'h0, 4'hF, 2, 32'h00BB00DD, "alias read");
        @(negedge clk);
        check_output("readdata hold", rd1, 32'h00BB00DD);
        check_output("no error w1", 32'(pe1), 32'd0);
        @(posedge clk);
        #1;

        // Back-to-back on the three-wait-cycle slave
        apply_stimulus(1, 0, 32'h00000020, 32'h12345678, 4'hF, 4, 32'h0, "b2b write");
        apply_stimulus(1, 1, 32'h00000020, 32'h0, 4'hF, 4, 32'h12345678, "b2b read");

        sel       = 1'b1;
        address   = 32'h00000020;
        writedata = 32'h0;
        read      = 1'b1;
        write     = 1'b1;
        @(negedge clk);
        check_output("both high waitrequest", 32'(wr3), 32'd1);
        @(posedge clk);
        #1;
        check_output("both high error", 32'(pe3), 32'd1);
        read  = 1'b0;
        write = 1'b0;
        @(posedge clk);
        #1;
        apply_stimulus(1, 1, 32'h00000020, 32'h0, 4'hF, 4, 32'h12345678, "after both high");

        sel        = 1'b0;
        address    = 32'h00000030;
        writedata  = 32'hDEADBEEF;
        byteenable = 4'hF;
        write      = 1'b1;
        @(posedge clk);
        #1 address = 32'h00000034;
        @(posedge clk);
        #1;
        check_output("address change error", 32'(pe1), 32'd1);
        write = 1'b0;
        @(posedge clk);
        #1;
        apply_stimulus(0, 1, 32'h00000030, 32'h0, 4'hF, 2, 32'h0, "aborted old addr");
        apply_stimulus(0, 1, 32'h00000034, 32'h0, 4'hF, 2, 32'h0, "aborted new addr");

        // Reset lands while the write is still stalling
        sel        = 1'b1;
        address    = 32'h00000020;
        writedata  = 32'h55555555;
        byteenable = 4'hF;
        write      = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_output("mid reset waitrequest", 32'(wr3), 32'd1);
        check_output("mid reset error clear", 32'(pe3), 32'd0);
        check_output("mid reset readdata", rd3, 32'd0);
        write = 1'b0;
        @(negedge clk);
        check_output("held reset waitrequest", 32'(wr3), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_output("post reset idle", 32'(wr3), 32'd0);
        @(posedge clk);
        #1;
        apply_stimulus(1, 1, 32'h00000020, 32'h0, 4'hF, 4, 32'h12345678, "after mid reset");

        check_output("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_checks++;
        n_fail++;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
